block_mem_responder: RTL and testbench

- Multi-cycle, block-granular backing memory that answers the cache's refill and write-back requests.
- Sits below the data cache on its memory-side interface.
- Accepts one read or write of a whole line per request and completes it after a fixed programmable delay.
- Uses the same valid/ready handshake the cache drives: is_input_valid, mem_read/mem_write, mem_ready, is_output_valid.

---
 rtl/block_mem_responder_pkg.sv | 20 ++
 rtl/block_mem_array.sv | 57 +++++
 rtl/block_mem_responder.sv | 115 +++++++++++
 tb/tb_block_mem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_mem_responder_pkg.sv
// rtl/block_mem_responder_pkg.sv - shared state encoding and width helper for the block memory responder
//
// Contents:
//   mem_state_t : responder FSM states (MEM_IDLE=0, MEM_BUSY=1, MEM_DONE=2)
//   clog2_min1  : ceiling log2 that never returns 0, for sizing index and counter fields

package block_mem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    // A one-bit field is still needed when the value range collapses to {0,1}.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/block_mem_array.sv
// rtl/block_mem_array.sv - line storage with one synchronous write port and one combinational read port
//
// Optional feature macro: BLOCK_MEM_CLEAR_EN (clear input wipes every line while high).
//
// Ports:
//   clk    in  rising-edge clock
//   we     in  write enable, line written at the edge
//   waddr  in  write line index
//   wdata  in  write line data
//   raddr  in  read line index
//   rdata  out read line data, combinational
//   clear  in  clear all lines to zero (only acted on with BLOCK_MEM_CLEAR_EN)

module block_mem_array
    import block_mem_responder_pkg::*;
#(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_BLOCKS = 256
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [clog2_min1(NUM_BLOCKS)-1:0]   waddr,
    input  logic [BLOCK_SIZE*8-1:0]             wdata,
    input  logic [clog2_min1(NUM_BLOCKS)-1:0]   raddr,
    output logic [BLOCK_SIZE*8-1:0]             rdata,
    input  logic                                clear
);

    localparam int DATA_W = BLOCK_SIZE * 8;

    logic [DATA_W-1:0] mem [NUM_BLOCKS];

`ifdef BLOCK_MEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
`else
    // Contents survive reset; the clear request has no effect in this build.
    logic unused_clear;
    assign unused_clear = clear;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end
`endif

    assign rdata = mem[raddr];

endmodule

// File: rtl/block_mem_responder.sv
// rtl/block_mem_responder.sv - fixed-latency line read/write responder below the data cache
//
// Optional feature macro: BLOCK_MEM_CLEAR_EN (storage cleared on every cycle reset is low).
//
// Ports:
//   clk             in  rising-edge clock
//   reset           in  synchronous active-low reset
//   is_input_valid  in  request present this cycle
//   addr            in  block address; low index bits select the line, upper bits alias
//   mem_read        in  request is a line read
//   mem_write       in  request is a line write
//   din             in  line write data
//   is_output_valid out one-cycle pulse when a read completes
//   dout            out read data, held until the next read completes
//   mem_ready       out high only while idle

module block_mem_responder
    import block_mem_responder_pkg::*;
#(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_BLOCKS = 256,
    parameter int DELAY      = 50
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     is_input_valid,
    input  logic [31:0]              addr,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [BLOCK_SIZE*8-1:0]  din,
    output logic                     is_output_valid,
    output logic [BLOCK_SIZE*8-1:0]  dout,
    output logic                     mem_ready
);

    localparam int DATA_W = BLOCK_SIZE * 8;
    localparam int IDX_W  = clog2_min1(NUM_BLOCKS);
    localparam int CNT_W  = clog2_min1(DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);

    mem_state_t state;
    mem_state_t state_next;

    logic [CNT_W-1:0]  counter;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] din_q;
    logic              op_write_q;

    logic              accept;
    logic              finish;
    logic              array_we;
    logic [DATA_W-1:0] rd_data;

    // Address bits above the index only alias onto the same storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:IDX_W];

    // Requests asserting both or neither operation are dropped while idle.
    assign accept = (state == MEM_IDLE) && is_input_valid && (mem_read ^ mem_write);
    assign finish = (state == MEM_BUSY) && (counter == '0);

    // Gated by reset so an aborted write never lands in storage.
    assign array_we = finish && op_write_q && reset;

    always_comb begin
        state_next = state;
        case (state)
            MEM_IDLE: if (accept) state_next = MEM_BUSY;
            MEM_BUSY: if (counter == '0) state_next = MEM_DONE;
            MEM_DONE: state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    assign mem_ready       = (state == MEM_IDLE);
    assign is_output_valid = (state == MEM_DONE) && !op_write_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= MEM_IDLE;
            counter    <= '0;
            dout       <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            din_q      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx_q      <= addr[IDX_W-1:0];
                din_q      <= din;
                op_write_q <= mem_write;
                counter    <= CNT_LOAD;
            end else if ((state == MEM_BUSY) && (counter != '0)) begin
                counter <= counter - 1'b1;
            end
            if (finish && !op_write_q) begin
                dout <= rd_data;
            end
        end
    end

    block_mem_array #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .waddr (idx_q),
        .wdata (din_q),
        .raddr (idx_q),
        .rdata (rd_data),
        .clear (!reset)
    );

endmodule

// File: tb/tb_block_mem_responder.sv
// tb/tb_block_mem_responder.sv - self-checking bench with a cycle-level transaction model

module tb_block_mem_responder;

    localparam int BS = 16;
    localparam int NB = 256;
    localparam int DL = 50;
    localparam int W  = BS * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          is_input_valid;
    logic [31:0]   addr;
    logic          mem_read;
    logic          mem_write;
    logic [W-1:0]  din;
    logic          is_output_valid;
    logic [W-1:0]  dout;
    logic          mem_ready;

    block_mem_responder #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .DELAY(DL)) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .mem_ready       (mem_ready)
    );

    // Second instance: DELAY=1 with a read held valid continuously.
    logic        d1_valid;
    logic [31:0] d1_addr;
    logic [15:0] d1_din;
    logic [15:0] d1_dout;
    logic        d1_ovalid;
    logic        d1_ready;

    block_mem_responder #(.BLOCK_SIZE(2), .NUM_BLOCKS(4), .DELAY(1)) dut_d1 (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (d1_valid),
        .addr            (d1_addr),
        .mem_read        (1'b1),
        .mem_write       (1'b0),
        .din             (d1_din),
        .is_output_valid (d1_ovalid),
        .dout            (d1_dout),
        .mem_ready       (d1_ready)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] mdl [NB];
    bit           known [NB];
    bit           model_on = 0;
    bit           m_busy;
    bit           m_read;
    int           m_done;
    int           m_idx;
    logic [W-1:0] m_data;
    bit           e_ready;
    bit           e_valid;
    logic [W-1:0] e_dout;
    bit           e_dout_known;
    int           cyc = 0;

    // Inputs change just after the rising edge, so at the falling edge they are
    // exactly what the next rising edge will sample.
    initial begin
        for (int i = 0; i < NB; i++) known[i] = 0;
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("ready", W'(mem_ready), W'(e_ready));
                check("valid", W'(is_output_valid), W'(e_valid));
                if (e_dout_known) check("dout", dout, e_dout);
            end
            cyc = cyc + 1;
            if (reset === 1'b0) begin
                model_on     = 1;
                m_busy       = 0;
                e_ready      = 1;
                e_valid      = 0;
                e_dout       = '0;
                e_dout_known = 1;
`ifdef BLOCK_MEM_CLEAR_EN
                for (int i = 0; i < NB; i++) begin
                    mdl[i]   = '0;
                    known[i] = 1;
                end
`endif
            end else if (model_on) begin
                if (e_ready && is_input_valid && (mem_read != mem_write)) begin
                    m_busy = 1;
                    m_done = cyc + DL;
                    m_read = mem_read;
                    m_idx  = int'(addr % NB);
                    m_data = din;
                end
                e_valid = 0;
                if (m_busy && cyc == m_done) begin
                    if (m_read) begin
                        e_valid      = 1;
                        e_dout       = mdl[m_idx];
                        e_dout_known = known[m_idx];
                    end else begin
                        mdl[m_idx]   = m_data;
                        known[m_idx] = 1;
                    end
                end else if (m_busy && cyc == m_done + 1) begin
                    m_busy = 0;
                end
                e_ready = !m_busy;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
    endtask

    // Returns shortly after the accepting edge; the next falling edge is the first busy cycle.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [W-1:0] d);
        step();
        is_input_valid = 1'b1;
        mem_read       = rd;
        mem_write      = wr;
        addr           = a;
        din            = d;
        step();
        idle_inputs();
    endtask

    task automatic run_write(input logic [31:0] a, input logic [W-1:0] d, input bit timing);
        int low;
        int pulses;
        int first_high;
        low = 0; pulses = 0; first_high = -1;
        issue(1'b0, 1'b1, a, d);
        for (int k = 0; k < DL + 10; k++) begin
            @(negedge clk);
            if (!mem_ready) low++;
            else if (first_high < 0) first_high = k;
            if (is_output_valid) pulses++;
        end
        if (timing) begin
            check("wr_ready_low_cycles", W'(low), W'(DL + 1));
            check("wr_ready_return", W'(first_high), W'(DL + 1));
            check("wr_no_pulse", W'(pulses), W'(0));
        end
    endtask

    task automatic run_read(input string name, input logic [31:0] a, input logic [W-1:0] exp);
        int pulses;
        int pulse_k;
        logic [W-1:0] got;
        pulses = 0; pulse_k = -1; got = '0;
        issue(1'b1, 1'b0, a, '0);
        for (int k = 0; k < DL + 10; k++) begin
            @(negedge clk);
            if (is_output_valid) begin
                pulses++;
                pulse_k = k;
                got     = dout;
            end
        end
        check({name, "_pulses"}, W'(pulses), W'(1));
        check({name, "_latency"}, W'(pulse_k), W'(DL));
        check({name, "_data"}, got, exp);
        check({name, "_hold"}, dout, exp);
    endtask

    localparam logic [W-1:0] V5 = 128'hDEADBEEF_00000001_00000002_00000003;
    localparam logic [W-1:0] V7 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    initial begin
        int low;
        logic [W-1:0] exp7;
        reset    = 1'b1;
        idle_inputs();
        addr     = '0;
        din      = '0;
        d1_valid = 1'b1;
        d1_addr  = 32'd1;
        d1_din   = '0;

        // Reset for two edges.
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", W'(mem_ready), W'(1));
        check("rst_valid", W'(is_output_valid), W'(0));
        check("rst_dout", dout, '0);

        // DELAY=1 instance with a held read: IDLE, BUSY, DONE repeating.
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            check("d1_ready", W'(d1_ready), W'((k % 3) == 0));
            check("d1_valid", W'(d1_ovalid), W'((k % 3) == 2));
        end
        d1_valid = 1'b0;

        run_write(32'd5, V5, 1'b1);
        run_read("rd5", 32'd5, V5);
        run_read("rd_alias", 32'd5 + NB, V5);

        // Illegal requests are never accepted.
        issue(1'b1, 1'b1, 32'd5, '0);
        issue(1'b0, 1'b0, 32'd5, '0);
        low = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!mem_ready) low++;
        end
        check("illegal_ready_low", W'(low), W'(0));

        // Reset in the middle of a write leaves the old contents.
        run_write(32'd7, V7, 1'b0);
        issue(1'b0, 1'b1, 32'd7, '1);
        repeat (19) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", W'(mem_ready), W'(1));
        check("abort_valid", W'(is_output_valid), W'(0));
`ifdef BLOCK_MEM_CLEAR_EN
        exp7 = '0;
`else
        exp7 = V7;
`endif
        run_read("rd_abort", 32'd7, exp7);

        // Randomized traffic over a small index set with aliased upper bits.
        for (int n = 0; n < 4000; n++) begin
            step();
            reset          = ($urandom_range(0, 599) != 0);
            is_input_valid = $urandom_range(0, 1) == 1;
            {mem_read, mem_write} = 2'($urandom_range(0, 3));
            addr           = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7));
            din            = {$urandom, $urandom, $urandom, $urandom};
        end
        step();
        reset = 1'b1;
        idle_inputs();
        repeat (DL + 5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
